mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle RV32M execution unit; consumes decode ops with ALU_CNT = alu_mstd plus FUN3.
//  Sits in EX beside the single-cycle ALU. Pipeline holds the instruction while BUSY.
//  Returns one 32-bit result with a single-cycle DONE pulse.
//  Shift-add multiply and restoring divide share one operand/accumulator datapath.
// PARAMETERS
//  XLEN     32   operand/result width; iteration count = XLEN
// PORTS
//  CLK      in   1     clock; all state updates on rising edge
//  RST      in   1     reset, synchronous, active-high
//  START    in   1     launch op; sampled only in IDLE
//  FUN3     in   3     000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
//  RS1      in   XLEN  operand A (dividend / multiplicand)
//  RS2      in   XLEN  operand B (divisor / multiplier)
//  CANCEL   in   1     pipeline flush; abort the in-flight op
//  BUSY     out  1     high from the cycle after START until the DONE cycle, inclusive
//  DONE     out  1     one-cycle pulse; RESULT valid in this cycle
//  RESULT   out  XLEN  result; held stable after DONE until the next accepted START
// BEHAVIOUR
//  Reset: state IDLE, BUSY=0, DONE=0, RESULT=0, all internal registers cleared.
//  Reset mid-operation: same values next cycle; no DONE is produced for the aborted op.
//  FSM states: IDLE -> {MUL | DIV} -> FIXUP -> FIN -> IDLE.
//  IDLE
//   - START=1 and CANCEL=0: latch FUN3 and operand magnitudes; latch result sign.
//   - Signedness: mul/mulh signed x signed; mulhsu signed x unsigned; mulhu/divu/remu unsigned.
//   - div/rem: signed.
//  MUL/DIV: exactly XLEN iterations, one bit per cycle; 64-bit product/remainder accumulator.
//  FIXUP
//   - Select low or high word.
//   - Two's-complement negate when the result sign is set.
//   - rem sign follows the dividend.
//  FIN
//   - DONE=1, RESULT is registered, BUSY=1.
//   - Next cycle: IDLE, BUSY=0.
//  Latency: START in cycle t -> DONE in cycle t+XLEN+2 for all normal cases.
//  Divide special cases (bypass the iteration; FIXUP -> FIN, DONE at t+2):
//   - Divide by zero: div/divu -> all ones; rem/remu -> RS1.
//   - Signed overflow (RS1 = 0x80000000, RS2 = -1): div -> 0x80000000; rem -> 0.
//  START while BUSY: ignored; the in-flight op is unaffected.
//  Back-to-back: START accepted in the cycle after FIN, so minimum issue interval is XLEN+3.
//  CANCEL
//   - Any non-IDLE state -> IDLE next cycle, BUSY=0, no DONE.
//   - RESULT keeps its previous value.
//  START and CANCEL in the same cycle: CANCEL wins; nothing is launched.
//  CANCEL in the FIN cycle: DONE still asserts in that cycle; the consumer discards it.
//  Arithmetic
//   - Magnitudes are XLEN-bit unsigned; negation wraps modulo 2^XLEN.
//   - |0x80000000| = 0x80000000 treated as unsigned.
// STRUCTURE
//  FUN3 M-op encodings, alu_mstd and FSM state codes belong in the shared PipelineParams.vh.
//  One sub-module is natural:
//   - mdu_iter_core: per-cycle shift-add / restore-subtract step on the accumulator.
//   - The top keeps the FSM, sign handling and special cases.
// TESTING
//  1. MUL 6 x 7 -> RESULT=0x0000002A, DONE at t+34, BUSY high t+1..t+34.
//  2. MULH 0x80000000 x 0x80000000 -> 0x40000000.
//     MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
//     MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF.
//  4. DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000;
//     REM of the same operands -> 0; all with DONE at t+2.
//  5. CANCEL at t+10 of a DIV -> BUSY=0 at t+11, no DONE, RESULT unchanged.
//     START+CANCEL in the same cycle -> no launch.
//  6. START pulsed at t+5 while BUSY -> ignored.
//     RST at t+8 -> all outputs 0 next cycle.
//     Fresh START after reset -> correct result.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIXUP,
    S_FIN
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic            start;
  logic [2:0]      fun3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            cancel;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, fun3, rs1, rs2, cancel,
                  input  busy, done, result);
  modport slave  (input  start, fun3, rs1, rs2, cancel,
                  output busy, done, result);
endinterface

// File: rtl/mul_div_unit_iter_core.sv
// One iteration of shift-add multiply or restoring divide on the 2*XLEN accumulator.
module mul_div_unit_iter_core
  import mul_div_unit_pkg::*;
(
  input  logic              is_div,
  input  logic [XLEN-1:0]   operand,
  input  logic [2*XLEN-1:0] acc,
  output logic [2*XLEN-1:0] acc_next_c
);

  logic [XLEN-1:0] addend_c;
  logic [XLEN:0]   sum_c;
  logic [XLEN:0]   rem_shift_c;
  logic [XLEN:0]   diff_c;

  always_comb begin
    addend_c    = acc[0] ? operand : '0;
    sum_c       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend_c};
    // Shifted partial remainder needs XLEN+1 bits before the trial subtract
    rem_shift_c = acc[2*XLEN-1:XLEN-1];
    diff_c      = rem_shift_c - {1'b0, operand};
    acc_next_c  = {sum_c, acc[XLEN-1:1]};
    if (is_div) begin
      if (!diff_c[XLEN]) begin
        acc_next_c = {diff_c[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next_c = {acc[2*XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M execution unit: FSM, sign handling and divide special cases.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic                neg_q;
  logic [XLEN-1:0]     operand_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;

  op_e                 op_in_c;
  logic                a_neg_c, b_neg_c, neg_in_c;
  logic [XLEN-1:0]     mag_a_c, mag_b_c;
  logic                div_zero_c, ovf_c, special_c;
  logic [XLEN-1:0]     special_val_c;
  logic                launch_c, load_result_c;
  logic [2*XLEN-1:0]   acc_step_c;
  logic [2*XLEN-1:0]   full_c;
  logic [XLEN-1:0]     word_c, fixup_c;

  mul_div_unit_iter_core u_iter_core (
    .is_div     (state_q == S_DIV),
    .operand    (operand_q),
    .acc        (acc_q),
    .acc_next_c (acc_step_c)
  );

  // Operand magnitudes, result sign and divide special cases at issue
  always_comb begin
    op_in_c  = op_e'(bus.fun3);
    a_neg_c  = 1'b0;
    b_neg_c  = 1'b0;
    if (op_in_c inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) a_neg_c = bus.rs1[XLEN-1];
    if (op_in_c inside {OP_MUL, OP_MULH, OP_DIV, OP_REM})            b_neg_c = bus.rs2[XLEN-1];
    mag_a_c  = a_neg_c ? -bus.rs1 : bus.rs1;
    mag_b_c  = b_neg_c ? -bus.rs2 : bus.rs2;
    neg_in_c = is_rem_op(op_in_c) ? a_neg_c : (a_neg_c ^ b_neg_c);

    div_zero_c = is_div_op(op_in_c) && (bus.rs2 == '0);
    ovf_c      = (op_in_c inside {OP_DIV, OP_REM}) &&
                 (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
    special_c  = div_zero_c || ovf_c;

    special_val_c = '0;
    if (div_zero_c) begin
      special_val_c = is_rem_op(op_in_c) ? bus.rs1 : '1;
    end else if (ovf_c) begin
      special_val_c = is_rem_op(op_in_c) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Next state and control strobes
  always_comb begin
    state_d       = state_q;
    launch_c      = 1'b0;
    load_result_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          launch_c = 1'b1;
          if (special_c)                 state_d = S_FIXUP;
          else if (is_div_op(op_in_c))   state_d = S_DIV;
          else                           state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        state_d       = S_FIN;
        load_result_c = !bus.cancel;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && bus.cancel) state_d = S_IDLE;
  end

  // Word select and sign correction; mul negates the full product, div/rem the chosen word
  always_comb begin
    full_c  = neg_q ? -acc_q : acc_q;
    word_c  = is_rem_op(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    fixup_c = neg_q ? -word_c : word_c;
    case (op_q)
      OP_MUL:                       fixup_c = full_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixup_c = full_c[2*XLEN-1:XLEN];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      operand_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.busy <= (state_d != S_IDLE);
      bus.done <= (state_d == S_FIN);
      if (launch_c) begin
        op_q  <= op_in_c;
        cnt_q <= '0;
        // Special results are mirrored into both halves so either word select picks them up
        if (special_c) begin
          neg_q     <= 1'b0;
          operand_q <= '0;
          acc_q     <= {special_val_c, special_val_c};
        end else if (is_div_op(op_in_c)) begin
          neg_q     <= neg_in_c;
          operand_q <= mag_b_c;
          acc_q     <= {{XLEN{1'b0}}, mag_a_c};
        end else begin
          neg_q     <= neg_in_c;
          operand_q <= mag_a_c;
          acc_q     <= {{XLEN{1'b0}}, mag_b_c};
        end
      end else if (state_q == S_MUL || state_q == S_DIV) begin
        acc_q <= acc_step_c;
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_result_c) bus.result <= fixup_c;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if bus ();

  mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64, sp;
    logic [63:0] up;
    logic signed [31:0] sa, sb, sq;
    logic ovf;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'b0, b};
    sa   = a;
    sb   = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin sp = sa64 * sb64;             return sp[63:32]; end
      3'd2: begin sp = sa64 * ub64;             return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        sq = sa % sb; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return XLEN + 2;
  endfunction

  // Issue one op in the current cycle and follow it to its DONE pulse
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int glitch_at);
    int lat;
    int n;
    logic seen;
    lat  = exp_latency(f, a, b);
    seen = 1'b0;
    bus.start = 1'b1; bus.fun3 = f; bus.rs1 = a; bus.rs2 = b;
    step();
    n = 1;
    while (n < 80) begin
      if (n == glitch_at) begin
        bus.start = 1'b1; bus.fun3 = 3'b101; bus.rs1 = $urandom; bus.rs2 = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      if (n == 1) check({tag, " busy_t1"}, 32'(bus.busy), 32'd1);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      step();
      n++;
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " result"}, bus.result, exp);
    check({tag, " busy_fin"}, 32'(bus.busy), 32'd1);
    step();
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " done_after"}, 32'(bus.done), 32'd0);
    last_result = exp;
  endtask

  task automatic expect_no_done(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      if (bus.done) seen = 1'b1;
      step();
    end
    check({tag, " no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.fun3 = '0; bus.rs1 = '0; bus.rs2 = '0;
    rst = 1'b1;
    step(); step();
    check("reset busy",   32'(bus.busy), 32'd0);
    check("reset done",   32'(bus.done), 32'd0);
    check("reset result", bus.result,    32'd0);
    rst = 1'b0;

    run_op("mul 6x7",   3'd0, 32'd6,          32'd7,          32'h0000_002A, -1);
    run_op("mulh",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, -1);
    run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, -1);
    run_op("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    run_op("div -7/2",  3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, -1);
    run_op("rem -7/2",  3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, -1);
    run_op("divu",      3'd5, 32'hFFFF_FFFE, 32'd2,          32'h7FFF_FFFF, -1);
    run_op("div 5/0",   3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, -1);
    run_op("remu 5/0",  3'd7, 32'd5,          32'd0,          32'd5,         -1);
    run_op("div ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
    run_op("rem ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, -1);

    // Cancel a divide in cycle t+10
    bus.start = 1'b1; bus.fun3 = 3'd4; bus.rs1 = 32'd1000; bus.rs2 = 32'd7;
    step();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("cancel busy",   32'(bus.busy), 32'd0);
    check("cancel done",   32'(bus.done), 32'd0);
    check("cancel result", bus.result,    last_result);
    expect_no_done("cancel");

    // START and CANCEL together launch nothing
    bus.start = 1'b1; bus.cancel = 1'b1; bus.fun3 = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd3;
    step();
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("start+cancel busy", 32'(bus.busy), 32'd0);
    expect_no_done("start+cancel");
    check("start+cancel result", bus.result, last_result);

    run_op("mul glitch", 3'd0, 32'd123456, 32'd789, ref_model(3'd0, 32'd123456, 32'd789), 5);

    // Reset in cycle t+8 of a multiply
    bus.start = 1'b1; bus.fun3 = 3'd1; bus.rs1 = 32'h1234_5678; bus.rs2 = 32'h9ABC_DEF0;
    step();
    bus.start = 1'b0;
    for (int k = 1; k < 8; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy",   32'(bus.busy), 32'd0);
    check("midrst done",   32'(bus.done), 32'd0);
    check("midrst result", bus.result,    32'd0);
    last_result = '0;
    expect_no_done("midrst");
    run_op("after rst", 3'd5, 32'd100, 32'd7, 32'd14, -1);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rand%0d f%0d", i, f), f, a, b, ref_model(f, a, b), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
